i2c_temp_responder: RTL
=======================

// Module: i2c_temp_responder
// PURPOSE
// - I2C target (responder) emulating the on-board temperature sensor's register interface.
// - Sits opposite the I2C master on the SCL/SDA pair, in simulation benches or a second board.
// - Serves a 16-bit temperature register, supplied on temp_reg, to any master that reads it.
// - Oversamples SCL/SDA on the 100 MHz system clock; the block never drives SCL.
// PARAMETERS
// - DEV_ADDR    7'h4B  7-bit target address matched after START
// - ID_VALUE    8'hCB  value returned for pointer 8'h0B (ID register)
// - FILTER_LEN  4      consecutive stable samples required (GLITCH_FILTER_EN builds only)
// PORTS
// - clk_100MHz  in     1   system clock; sole clock domain
// - reset       in     1   synchronous, active-high reset
// - SCL         in     1   I2C clock from the master
// - SDA         inout  1   open-drain data; driven only to 0, otherwise 1'bz
// - temp_reg    in     16  live temperature word {MSB, LSB}
// - busy        out    1   high from address match until STOP or a mismatch
// - rd_done     out    1   1-cycle pulse each time a transmitted byte is master-ACKed/NACKed
// BEHAVIOUR
// - Input conditioning: 2-FF synchronizer on SCL and SDA, then edge detect on the synced copies.
//   - All decisions use synced signals.
// - Bus conditions (evaluated only while SCL_s is high):
//   - START: SDA_s falls. STOP: SDA_s rises.
//   - START is honoured in any state, including mid-byte (repeated START).
//   - On START: enter ADDR, bit count = 0.
//   - STOP forces IDLE from any state and releases SDA.
// - Bit timing:
//   - Sample SDA on SCL_s rising edge.
//   - Change our SDA drive on SCL_s falling edge, so drive is valid 2-3 clk_100MHz after the fall.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, MACK, WAIT_STOP.
//   - ADDR: shift 8 bits MSB-first.
//     - {DEV_ADDR, R/W} match: pull SDA low for the 9th clock (ADDR_ACK) and set busy.
//     - Mismatch: go to WAIT_STOP with SDA released; busy stays 0.
//   - ADDR_ACK, then on the falling edge ending the ACK clock:
//     - R/W=0: go to PTR, release SDA.
//     - R/W=1: go to TX and drive bit 7 of the current byte.
//   - PTR: shift 8 bits, load pointer, ACK in PTR_ACK, then go to PTR again.
//     - Further bytes overwrite the pointer; each byte is ACKed.
//   - TX: shift out the byte, releasing SDA for 1s.
//     - After bit 0, release SDA and go to MACK.
//   - MACK: sample the master's bit on the SCL rise and pulse rd_done.
//     - ACK (0): pointer+1, back to TX.
//     - NACK (1): go to WAIT_STOP.
//   - WAIT_STOP: SDA released; wait for STOP or START.
// - Register map by pointer:
//   - 8'h00 = MSB, 8'h01 = LSB, 8'h0B = ID_VALUE, all others = 8'h00.
//   - Pointer is 8-bit and wraps 8'hFF -> 8'h00.
//   - Pointer persists across transactions; reset value 8'h00.
// - Snapshot: temp_reg is captured on every read-address match.
//   - MSB and LSB of one transaction always come from the same sample.
// - Reset values:
//   - SDA released (z), busy=0, rd_done=0, state IDLE, pointer 8'h00, synchronizers all 1.
// - Reset mid-transfer: SDA is released on the first clock edge with reset high.
// - No clock stretching; the master's SCL timing is assumed legal (<=400 kHz).
// CONFIGURATION
// - GLITCH_FILTER_EN defined:
//   - After synchronization, SCL/SDA pass through a filter.
//   - A filtered output changes only after FILTER_LEN consecutive equal samples.
//   - Adds FILTER_LEN cycles of latency to all edge decisions.
// - GLITCH_FILTER_EN undefined: synchronizer output is used directly; FILTER_LEN is ignored.
// TESTING
// - temp_reg=16'h1A80; START, 0x97, read 2 bytes (ACK, NACK), STOP
//   -> address ACKed, bytes 0x1A, 0x80, two rd_done pulses, busy low after STOP.
// - START, 0x90 (addr 0x48)
//   -> SDA never driven, busy stays 0, no ACK, IDLE after STOP.
// - Write pointer 0x0B, repeated START, read 1 byte -> 0xCB.
//   - Next read at pointer 0x0C -> 0x00.
// - Start reading 0x1A80; change temp_reg to 16'h2200 after the MSB
//   -> LSB read is 0x80 (snapshot); next transaction returns 0x22, 0x00.
// - Assert reset during TX bit 3 of a 0x00 byte
//   -> SDA released next clock, busy=0, pointer 8'h00.
// - GLITCH_FILTER_EN: 2-cycle low pulse on SDA while SCL high
//   -> no START detected, state stays IDLE.

Source files
------------

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the temperature sensor register file (MSB, LSB, ID).
// Optional input glitch filter on synced SCL/SDA: define GLITCH_FILTER_EN.
module i2c_temp_responder #(
  parameter logic [6:0]  DEV_ADDR   = 7'h4B,
  parameter logic [7:0]  ID_VALUE   = 8'hCB,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_reg,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, MACK, WAIT_STOP
  } state_e;

  state_e      state_q;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic        scl_rise, scl_fall, start_c, stop_c;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q, tx_q, ptr_q, cur_byte;
  logic [15:0] snap_q;
  logic        sda_oe_q, busy_q, rd_done_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], SCL};
      sda_sync_q <= {sda_sync_q[0], SDA};
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]         raw_s, filt_q;
  logic [1:0][CW-1:0] fcnt_q;
  assign raw_s = {scl_sync_q[1], sda_sync_q[1]};

  // Output follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= raw_s[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign scl_s = filt_q[1];
  assign sda_s = filt_q[0];
`else
  logic unused_cfg;
  assign unused_cfg = (FILTER_LEN != 0);
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    cur_byte = 8'h00;
    case (ptr_q)
      8'h00:   cur_byte = snap_q[15:8];
      8'h01:   cur_byte = snap_q[7:0];
      8'h0B:   cur_byte = ID_VALUE;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      snap_q    <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      if (stop_c) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_c) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, PTR: begin
            if (bit_cnt_q < 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          MACK: begin
            rd_done_q <= 1'b1;
            if (!sda_s) begin
              ptr_q     <= ptr_q + 8'd1;
              state_q   <= TX;
              bit_cnt_q <= '0;
            end else begin
              state_q <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: begin
            if (bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= ADDR_ACK;
                if (shift_q[0]) snap_q <= temp_reg;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (shift_q[0]) begin
              sda_oe_q  <= ~cur_byte[7];
              tx_q      <= {cur_byte[6:0], 1'b0};
              bit_cnt_q <= 4'd1;
              state_q   <= TX;
            end else begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= PTR;
            end
          end
          PTR: begin
            if (bit_cnt_q == 4'd8) begin
              ptr_q    <= shift_q;
              sda_oe_q <= 1'b1;
              state_q  <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= PTR;
          end
          TX: begin
            // bit_cnt counts bits already put on the wire; 0 means load a fresh byte.
            if (bit_cnt_q == 4'd0) begin
              sda_oe_q  <= ~cur_byte[7];
              tx_q      <= {cur_byte[6:0], 1'b0};
              bit_cnt_q <= 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_q <= 1'b0;
              state_q  <= MACK;
            end else begin
              sda_oe_q  <= ~tx_q[7];
              tx_q      <= {tx_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;

endmodule
